// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: reads a raster-order image out of a synchronous ROM
// and emits it to mnist_process as IMG_H row bursts of IMG_W pixels, with a
// reset pulse to the classifier ahead of every frame and optional auto-repeat.
module mnist_frame_streamer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_W     = 11,
    parameter int ROW_GAP    = 5,
    parameter int RST_CYCLES = 1,
    parameter int FRAME_GAP  = 40000
) (
    input  logic              cmos_pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              repeat_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [15:0]       rom_data,
    output logic              proc_rst_n,
    output logic              mnist_data_valid,
    output logic [7:0]        mnist_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_LEAD, S_ROW, S_GAP, S_TAIL, S_WAIT
    } state_e;

    // One shared down-counter times the reset pulse, the row gaps and the frame gap.
    localparam int MAX_LOAD = (FRAME_GAP > ROW_GAP)
                            ? ((FRAME_GAP > RST_CYCLES) ? FRAME_GAP : RST_CYCLES)
                            : ((ROW_GAP > RST_CYCLES) ? ROW_GAP : RST_CYCLES);
    localparam int CNT_W = $clog2(MAX_LOAD + 1);
    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(ROW_GAP - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FRAME_GAP - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic last_col, last_row, cnt_zero;
    logic unused_rom_low;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign cnt_zero = (cnt_q == '0);

    // The low ROM byte carries nothing for the classifier.
    assign unused_rom_low = ^rom_data[7:0];

    // State and datapath registers; reset leaves a quiet, idle streamer.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state decode of the frame sequencer.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start || repeat_en) state_d = S_RST;
            S_RST:  if (cnt_zero) state_d = S_LEAD;
            S_LEAD: state_d = S_ROW;
            S_ROW:  if (last_col) state_d = last_row ? S_TAIL : S_GAP;
            S_GAP:  if (cnt_zero) state_d = S_ROW;
            S_TAIL: state_d = repeat_en ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!repeat_en)    state_d = S_IDLE;
                else if (cnt_zero) state_d = S_RST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter and address updates: loads on state entry, steps within a state.
    always_comb begin
        cnt_d  = cnt_q;
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        unique case (state_q)
            S_IDLE: begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
                if (start || repeat_en) cnt_d = RST_LOAD;
            end
            S_RST, S_GAP: if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            S_ROW: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                        cnt_d = GAP_LOAD;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_TAIL: begin
                addr_d = '0;
                cnt_d  = repeat_en ? WAIT_LOAD : '0;
            end
            S_WAIT: begin
                if (!repeat_en)    cnt_d = '0;
                else if (cnt_zero) cnt_d = RST_LOAD;
                else               cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Output decode; valid and frame_done are the registered echoes of ROW and TAIL.
    always_comb begin
        rom_en     = (state_q == S_ROW);
        proc_rst_n = (state_q != S_RST);
        busy       = (state_q == S_RST) || (state_q == S_LEAD) || (state_q == S_ROW)
                  || (state_q == S_GAP) || (state_q == S_TAIL);
        rom_addr   = addr_q;
        valid_d    = rom_en;
        done_d     = (state_q == S_TAIL);
    end

    assign mnist_data_valid = valid_q;
    assign mnist_data       = rom_data[15:8];
    assign frame_done       = done_q;

endmodule
